// File: rtl/clock_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_multi
// Purpose  : Multi-channel programmable clock divider for the tone path.
//            Each channel divides clk by a runtime divisor A, producing a
//            near-50% duty square wave (high ceil(A/2), low floor(A/2)) and a
//            one-cycle tick at the start of every period. Divisor changes on
//            a running channel are deferred to the period boundary so the
//            output never shows a runt pulse; a global sync pulse restarts
//            every channel at phase 0.
// Ports    : clk     - system clock, rising edge
//            rst     - asynchronous active-low reset
//            wr_en   - divisor write strobe
//            wr_ch   - channel index for the write (out-of-range ignored)
//            wr_div  - divisor value, 0 disables the channel
//            sync    - one-cycle restart pulse for all channels
//            oclk    - divided square outputs (registered)
//            tick    - period-start pulses (registered)
//            pend    - written divisor waiting for its boundary (registered)
// Revision : 1.0 - initial release
// ============================================================================
module clock_divider_multi #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 16,
    parameter int RESET_DIV = 100
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(CHANNELS)-1:0] wr_ch,
    input  logic [WIDTH-1:0]            wr_div,
    input  logic                        sync,
    output logic [CHANNELS-1:0]         oclk,
    output logic [CHANNELS-1:0]         tick,
    output logic [CHANNELS-1:0]         pend
);

    localparam int               c_CHW       = $clog2(CHANNELS);
    localparam logic [WIDTH-1:0] c_RESET_DIV = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] c_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   c_ONE_X     = {{WIDTH{1'b0}}, 1'b1};

    // Low for exactly the first edge after reset release: that edge only
    // presents phase 0 on the outputs, counting starts on the following edge.
    logic r_run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] r_act;      // active divisor
        logic [WIDTH-1:0] r_pdiv;     // pending divisor
        logic [WIDTH-1:0] r_phase;    // phase counter, 0..r_act-1
        logic             r_pflag;
        logic             r_oclk;
        logic             r_tick;
        logic             r_pend;

        logic [WIDTH-1:0] w_act_n;
        logic [WIDTH-1:0] w_pdiv_n;
        logic [WIDTH-1:0] w_phase_n;
        logic             w_pflag_n;
        logic             w_wr;
        logic             w_wrap;
        logic [WIDTH:0]   w_high;     // ceil(A/2), one bit wider to avoid overflow

        // Equality decode naturally ignores indices >= CHANNELS.
        assign w_wr   = wr_en && (wr_ch == c_CHW'(i));
        assign w_wrap = r_run && (r_act != '0) && (r_phase == r_act - c_ONE);

        always_comb begin
            w_act_n   = r_act;
            w_pdiv_n  = r_pdiv;
            w_pflag_n = r_pflag;
            w_phase_n = (r_run && (r_act != '0)) ? r_phase + c_ONE : r_phase;

            if (sync) begin
                // A write on the sync edge wins over an older pending value.
                w_act_n   = w_wr ? wr_div : (r_pflag ? r_pdiv : r_act);
                w_pdiv_n  = '0;
                w_pflag_n = 1'b0;
                w_phase_n = '0;
            end else if (w_wr && ((r_act == '0) || w_wrap)) begin
                // Idle channel, or write landing exactly on the boundary:
                // nothing to protect, so apply at once.
                w_act_n   = wr_div;
                w_pdiv_n  = '0;
                w_pflag_n = 1'b0;
                w_phase_n = '0;
            end else if (w_wr) begin
                w_pdiv_n  = wr_div;
                w_pflag_n = 1'b1;
            end else if (w_wrap) begin
                if (r_pflag) begin
                    w_act_n = r_pdiv;
                end
                w_pdiv_n  = '0;
                w_pflag_n = 1'b0;
                w_phase_n = '0;
            end
        end

        assign w_high = ({1'b0, w_act_n} + c_ONE_X) >> 1;

        // Outputs are decoded from next-state values so they line up with
        // the phase held in the same cycle.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_act   <= c_RESET_DIV;
                r_pdiv  <= '0;
                r_phase <= '0;
                r_pflag <= 1'b0;
                r_oclk  <= 1'b0;
                r_tick  <= 1'b0;
                r_pend  <= 1'b0;
            end else begin
                r_act   <= w_act_n;
                r_pdiv  <= w_pdiv_n;
                r_phase <= w_phase_n;
                r_pflag <= w_pflag_n;
                r_oclk  <= (w_act_n != '0) && ({1'b0, w_phase_n} < w_high);
                r_tick  <= (w_act_n != '0) && (w_phase_n == '0);
                r_pend  <= w_pflag_n;
            end
        end

        assign oclk[i] = r_oclk;
        assign tick[i] = r_tick;
        assign pend[i] = r_pend;
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_divider_multi
// Purpose  : Self-checking bench for clock_divider_multi. Two instances:
//            dut_a (4 channels, reset divisor 100) and dut_b (5 channels,
//            reset divisor 0, 3-bit channel index so indices 5..7 are
//            out of range). Expected outputs come from a period-start model:
//            each channel remembers the edge its current period began and
//            its divisor, and the phase is (edge - start) mod A.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_divider_multi;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        wr_en  = 1'b0;
    logic        sync   = 1'b0;
    logic [2:0]  wr_ch3 = 3'd0;
    logic [15:0] wr_div = 16'd0;

    logic        wr_en_a;
    logic [1:0]  wr_ch_a;
    logic [3:0]  oclk_a, tick_a, pend_a;
    logic [4:0]  oclk_b, tick_b, pend_b;

    assign wr_en_a = wr_en && (wr_ch3 < 3'd4);
    assign wr_ch_a = wr_ch3[1:0];

    always #5 clk = ~clk;

    clock_divider_multi #(.CHANNELS(4), .WIDTH(16), .RESET_DIV(100)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_ch(wr_ch_a), .wr_div(wr_div),
        .sync(sync), .oclk(oclk_a), .tick(tick_a), .pend(pend_a)
    );

    clock_divider_multi #(.CHANNELS(5), .WIDTH(16), .RESET_DIV(0)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch3), .wr_div(wr_div),
        .sync(sync), .oclk(oclk_b), .tick(tick_b), .pend(pend_b)
    );

    int tests  = 0;
    int errors = 0;

    // Reference model state, [instance][channel]
    int     nch  [2] = '{4, 5};
    int     rdiv [2] = '{100, 0};
    int     mA   [2][8];
    int     mP   [2][8];
    bit     mpend[2][8];
    longint mstart[2][8];
    longint k;            // rising edges since reset release

    task automatic model_reset();
        k = 0;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 8; c++) begin
                mA[m][c]     = rdiv[m];
                mP[m][c]     = 0;
                mpend[m][c]  = 1'b0;
                mstart[m][c] = 1;
            end
        end
    endtask

    function automatic int mphase(input int m, input int c);
        if (mA[m][c] == 0) return -1;
        return int'((k - mstart[m][c]) % longint'(mA[m][c]));
    endfunction

    // Applies one rising edge (edge number k) to one model channel.
    task automatic model_edge(input int m, input int c, input bit en,
                              input int ch, input int div, input bit sy);
        bit wr;
        bit wrap;
        wr   = en && (ch == c);
        wrap = 1'b0;
        if (mA[m][c] != 0 && (k - 1) >= mstart[m][c])
            wrap = ((k - 1 - mstart[m][c]) % longint'(mA[m][c])) == longint'(mA[m][c] - 1);
        if (sy) begin
            mA[m][c]     = wr ? div : (mpend[m][c] ? mP[m][c] : mA[m][c]);
            mpend[m][c]  = 1'b0;
            mstart[m][c] = k;
        end else if (wr && (mA[m][c] == 0 || wrap)) begin
            mA[m][c]     = div;
            mpend[m][c]  = 1'b0;
            mstart[m][c] = k;
        end else if (wr) begin
            mP[m][c]    = div;
            mpend[m][c] = 1'b1;
        end else if (wrap) begin
            if (mpend[m][c]) mA[m][c] = mP[m][c];
            mpend[m][c]  = 1'b0;
            mstart[m][c] = k;
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] vo, vt, vp;
        int         a;
        longint     ph;
        bit         eo, et, ep;
        for (int m = 0; m < 2; m++) begin
            vo = (m == 0) ? {4'b0, oclk_a} : {3'b0, oclk_b};
            vt = (m == 0) ? {4'b0, tick_a} : {3'b0, tick_b};
            vp = (m == 0) ? {4'b0, pend_a} : {3'b0, pend_b};
            for (int c = 0; c < nch[m]; c++) begin
                a  = mA[m][c];
                ep = mpend[m][c];
                if (a == 0) begin
                    eo = 1'b0;
                    et = 1'b0;
                end else begin
                    ph = (k - mstart[m][c]) % longint'(a);
                    et = (ph == 0);
                    eo = (ph < longint'((a + 1) / 2));
                end
                tests++;
                assert (vo[c] === eo) else begin
                    errors++;
                    $error("FAIL %s oclk dut%0d ch%0d edge%0d: got %b exp %b", tag, m, c, k, vo[c], eo);
                end
                tests++;
                assert (vt[c] === et) else begin
                    errors++;
                    $error("FAIL %s tick dut%0d ch%0d edge%0d: got %b exp %b", tag, m, c, k, vt[c], et);
                end
                tests++;
                assert (vp[c] === ep) else begin
                    errors++;
                    $error("FAIL %s pend dut%0d ch%0d edge%0d: got %b exp %b", tag, m, c, k, vp[c], ep);
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        tests++;
        assert ({oclk_a, tick_a, pend_a} === 12'b0) else begin
            errors++;
            $error("FAIL %s dut0 outputs: got %b exp 0", tag, {oclk_a, tick_a, pend_a});
        end
        tests++;
        assert ({oclk_b, tick_b, pend_b} === 15'b0) else begin
            errors++;
            $error("FAIL %s dut1 outputs: got %b exp 0", tag, {oclk_b, tick_b, pend_b});
        end
    endtask

    // One clock: drive inputs, take the edge, advance model, check, idle inputs.
    task automatic step(input bit en, input int ch, input int div, input bit sy,
                        input string tag);
        wr_en  = en;
        wr_ch3 = ch[2:0];
        wr_div = div[15:0];
        sync   = sy;
        @(posedge clk);
        k++;
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < nch[m]; c++)
                model_edge(m, c, en, ch, div, sy);
        #1;
        check_all(tag);
        wr_en = 1'b0;
        sync  = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, tag);
    endtask

    // Bounded wait until the model shows phase ph on dut_a channel c.
    task automatic wait_phase_a(input int c, input int ph, input string tag);
        for (int i = 0; i < 200 && mphase(0, c) != ph; i++) idle(1, tag);
        tests++;
        assert (mphase(0, c) == ph) else begin
            errors++;
            $error("FAIL %s wait_phase ch%0d: got %0d exp %0d", tag, c, mphase(0, c), ph);
        end
    endtask

    initial begin
        bit en, sy;
        int ch, div;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;
        model_reset();

        // Free running at the reset divisor, all in phase
        idle(210, "reset_div");

        // Write to disabled channel 1 of dut_b (also reaches dut_a ch1 as pending)
        step(1'b1, 1, 7, 1'b0, "wr_disabled");
        idle(25, "div7");

        // Running channel 0 gets D=10 at its boundary, then D=4 written at p=3
        step(1'b1, 0, 10, 1'b0, "wr_running");
        idle(105, "to_div10");
        wait_phase_a(0, 3, "find_p3");
        step(1'b1, 0, 4, 1'b0, "wr_at_p3");
        idle(20, "div4");

        // Two writes before the boundary, last wins
        wait_phase_a(0, 0, "find_p0");
        step(1'b1, 0, 5, 1'b0, "wr5");
        step(1'b1, 0, 9, 1'b0, "wr9");
        idle(12, "div9");
        // Write landing on the wrap edge applies immediately
        wait_phase_a(0, 8, "find_wrap");
        step(1'b1, 0, 6, 1'b0, "wr_on_wrap");
        idle(15, "div6");

        // Channels 3,5,8,0 then sync
        step(1'b1, 0, 3, 1'b0, "set_ch0");
        step(1'b1, 1, 5, 1'b0, "set_ch1");
        step(1'b1, 2, 8, 1'b0, "set_ch2");
        step(1'b1, 3, 0, 1'b0, "set_ch3");
        idle(110, "chord");
        step(1'b0, 0, 0, 1'b1, "sync");
        idle(30, "after_sync");
        // Stop a running channel at its boundary
        step(1'b1, 0, 0, 1'b0, "wr_zero");
        idle(10, "stopped");

        // Randomised writes, syncs and out-of-range indices
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 3) == 0);
            ch  = $urandom_range(0, 7);
            div = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
            sy  = ($urandom_range(0, 39) == 0);
            step(en, ch, div, sy, "random");
        end

        // Reset mid-period with a pending write
        step(1'b1, 1, 5, 1'b1, "prep_sync");
        idle(2, "prep");
        step(1'b1, 1, 7, 1'b0, "wr_pending");
        rst = 1'b0;
        #1;
        check_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_hold");
        rst = 1'b1;
        model_reset();
        idle(130, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
